// File: rtl/draw_arbiter_pkg.sv
// rtl/draw_arbiter_pkg.sv - shared draw-engine indices, widths and arbiter state type
package draw_arbiter_pkg;

    localparam int NUM_ENG = 6;
    localparam int X_W     = 8;
    localparam int Y_W     = 7;
    localparam int C_W     = 3;
    localparam int WDOG_W  = 20;

    localparam int ENG_CLEAR   = 0;
    localparam int ENG_MAZE    = 1;
    localparam int ENG_ERASE   = 2;
    localparam int ENG_BOX     = 3;
    localparam int ENG_SPECIAL = 4;
    localparam int ENG_START   = 5;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_RELEASE = 2'd2
    } arb_state_t;

endpackage

// File: rtl/draw_priority_enc.sv
// rtl/draw_priority_enc.sv - fixed-priority select of the lowest-index pending engine
module draw_priority_enc
    import draw_arbiter_pkg::*;
(
    input  logic [NUM_ENG-1:0] pending,
    output logic [NUM_ENG-1:0] onehot,
    output logic               valid
);

    // Two's-complement trick isolates the lowest set bit.
    assign onehot = pending & (~pending + {{(NUM_ENG-1){1'b0}}, 1'b1});
    assign valid  = |pending;

endmodule

// File: rtl/draw_arbiter.sv
// rtl/draw_arbiter.sv - grants one draw engine at a time to the VGA adapter, with watchdog
module draw_arbiter
    import draw_arbiter_pkg::*;
#(
    parameter logic [WDOG_W-1:0] TIMEOUT_CYCLES = 20'd1048575
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic [NUM_ENG-1:0]     req,
    input  logic [NUM_ENG-1:0]     engine_done,
    input  logic [NUM_ENG*X_W-1:0] eng_x,
    input  logic [NUM_ENG*Y_W-1:0] eng_y,
    input  logic [NUM_ENG*C_W-1:0] eng_colour,
    input  logic [NUM_ENG-1:0]     eng_plot,
    output logic [NUM_ENG-1:0]     grant,
    output logic [X_W-1:0]         vga_x,
    output logic [Y_W-1:0]         vga_y,
    output logic [C_W-1:0]         vga_colour,
    output logic                   vga_plot,
    output logic [NUM_ENG-1:0]     done_pulse,
    output logic                   busy,
    output logic                   timeout_err
);

    arb_state_t          state;
    logic [NUM_ENG-1:0]  pending;
    logic [WDOG_W-1:0]   wdog;
    logic [NUM_ENG-1:0]  sel_onehot;
    logic                sel_valid;
    logic [NUM_ENG-1:0]  take_mask;

    draw_priority_enc u_prio (
        .pending (pending),
        .onehot  (sel_onehot),
        .valid   (sel_valid)
    );

    // Only the bit being granted this edge is consumed; a fresh req re-sets it.
    assign take_mask = (state == ST_IDLE && sel_valid) ? sel_onehot : '0;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state       <= ST_IDLE;
            pending     <= '0;
            grant       <= '0;
            done_pulse  <= '0;
            wdog        <= '0;
            timeout_err <= 1'b0;
        end else begin
            done_pulse <= '0;
            pending    <= (pending & ~take_mask) | req;
            case (state)
                ST_IDLE: begin
                    if (sel_valid) begin
                        grant <= sel_onehot;
                        wdog  <= '0;
                        state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (|(engine_done & grant)) begin
                        grant      <= '0;
                        done_pulse <= grant;
                        state      <= ST_RELEASE;
                    end else if (wdog == TIMEOUT_CYCLES - 1'b1) begin
                        grant       <= '0;
                        done_pulse  <= grant;
                        timeout_err <= 1'b1;
                        state       <= ST_RELEASE;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                ST_RELEASE: state <= ST_IDLE;
                default:    state <= ST_IDLE;
            endcase
        end
    end

    assign busy = (state == ST_BUSY);

    always_comb begin
        vga_x      = '0;
        vga_y      = '0;
        vga_colour = '0;
        for (int i = 0; i < NUM_ENG; i++) begin
            if (grant[i]) begin
                vga_x      = eng_x[i*X_W +: X_W];
                vga_y      = eng_y[i*Y_W +: Y_W];
                vga_colour = eng_colour[i*C_W +: C_W];
            end
        end
    end

    assign vga_plot = |(eng_plot & grant);

endmodule

// File: doc/draw_arbiter.md
DRAW_ARBITER -- requirements
Module: draw_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 20'd1048575, the maximum number of clocks a grant is held without engine_done.
REQ-002 The block SHALL have port clock  input  1  single system clock; all state updates on its rising edge.
REQ-003 The block SHALL have port resetn  input  1  reset, asynchronous and active-low.
REQ-004 The block SHALL have port req  input  6  draw request pulses from position control, indexed 0 clear, 1 maze, 2 erase, 3 box, 4 special, 5 start.
REQ-005 The block SHALL have port engine_done  input  6  per-engine completion, same indexing.
REQ-006 The block SHALL have port eng_x  input  48  packed 8-bit pixel X per engine, engine i at bits [8i+7:8i].
REQ-007 The block SHALL have port eng_y  input  42  packed 7-bit pixel Y per engine, engine i at bits [7i+6:7i].
REQ-008 The block SHALL have port eng_colour  input  18  packed 3-bit colour per engine, engine i at bits [3i+2:3i].
REQ-009 The block SHALL have port eng_plot  input  6  per-engine plot strobe.
REQ-010 The block SHALL have port grant  output  6  one-hot engine enable, all zero when idle.
REQ-011 The block SHALL have port vga_x, vga_y, vga_colour, vga_plot  output  8/7/3/1  muxed VGA adapter drive.
REQ-012 The block SHALL have port done_pulse  output  6  one-cycle completion back to position control.
REQ-013 The block SHALL have ports busy  output  1  grant active; timeout_err  output  1  sticky watchdog flag.

Function
REQ-014 A req[i] high at a rising edge SHALL set pending[i]; a repeat while pending[i] is already set SHALL be absorbed, not counted twice.
REQ-015 The FSM SHALL have states IDLE, BUSY, RELEASE.
REQ-016 In IDLE with pending nonzero, the next edge SHALL register grant to the lowest-index pending bit (fixed priority: clear > maze > erase > box > special > start), clear that pending bit, load the watchdog to zero, and enter BUSY.
REQ-017 A req[i] arriving on the same edge that grants i SHALL leave pending[i] set, so i is serviced again later.
REQ-018 In BUSY, engine_done[g] for the granted index g SHALL, on the next edge, clear grant, assert done_pulse[g] for exactly one cycle, and enter RELEASE.
REQ-019 engine_done for any non-granted index SHALL be ignored.
REQ-020 In BUSY, the watchdog SHALL increment each cycle; reaching TIMEOUT_CYCLES-1 without done SHALL release exactly as REQ-018 and set timeout_err.
REQ-021 RELEASE SHALL last one cycle, then go to IDLE, guaranteeing one idle clock between grants.
REQ-022 vga_x, vga_y, vga_colour SHALL be combinationally selected from the granted engine's slice, and zero when no grant.
REQ-023 vga_plot SHALL equal eng_plot[g] while busy and 0 otherwise.
REQ-024 busy SHALL be high exactly in BUSY.
REQ-025 Request-to-grant latency SHALL be 2 edges from an idle arbiter: one edge to set pending, one to grant.

Reset
REQ-026 resetn low SHALL immediately clear pending, grant, done_pulse, watchdog and timeout_err, force IDLE, and drive vga_plot 0, including mid-grant.
REQ-027 timeout_err SHALL clear only on reset.

Structure
REQ-028 Requester index constants, NUM_ENG=6, and the X/Y/colour widths SHALL live in the shared game package.
REQ-029 Priority selection SHALL be one sub-module, draw_priority_enc: 6-bit pending in, one-hot out plus valid.

Verification
REQ-030 Reset then req=6'b000010 pulse -> grant=6'b000010 two edges later; engine_done[1] -> done_pulse=6'b000010 for one cycle, then busy=0.
REQ-031 Simultaneous req=6'b001100 -> erase granted first; box granted after erase done plus the one-cycle RELEASE.
REQ-032 Granted box with eng_x[31:24]=8'd37, eng_y[27:21]=7'd12, eng_plot[3]=1 -> vga_x=37, vga_y=12, vga_plot=1; eng_plot[0]=1 alone -> vga_plot=0.
REQ-033 With TIMEOUT_CYCLES=16, no engine_done -> grant drops after 16 busy cycles, done_pulse pulses, timeout_err=1 until reset.
REQ-034 resetn low mid-grant -> grant=0, pending=0 asynchronously; a stale engine_done after release is ignored.
